// File: rtl/wb_master_seq.sv
// ----------------------------------------------------------------------------
// wb_master_seq
//   Wishbone classic initiator. A command accepted on the valid/ready command
//   channel becomes cmd_len_i+1 single-word WB cycles. The address advances by
//   4 per beat and wraps at 2^32. Write bursts repeat the same data word.
//   Every beat produces one response word on the valid/ready response channel.
//   A beat that sees no ACK within TIMEOUT strobe cycles is aborted. An aborted
//   beat returns an error response flagged as last, and any remaining beats are
//   dropped.
//
// Ports
//   wb_clk_i, wb_rst_ni          clock (rising edge), async active-low reset
//   cmd_valid_i / cmd_ready_o    command handshake
//   cmd_we_i, cmd_sel_i,         command fields: direction, byte selects,
//   cmd_adr_i, cmd_dat_i,        first byte address, fill data,
//   cmd_len_i                    beats minus one
//   rsp_valid_o / rsp_ready_i    response handshake
//   rsp_dat_o, rsp_err_o,        response fields: read data, timeout flag,
//   rsp_last_o                   final response of the command
//   wbm_*                        Wishbone master interface
//   busy_o                       high whenever the sequencer is not idle
//
// All outputs are driven directly from registers.
// ----------------------------------------------------------------------------
module wb_master_seq #(
    parameter int TIMEOUT = 255,
    parameter int LEN_W   = 4
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [3:0]       cmd_sel_i,
    input  logic [31:0]      cmd_adr_i,
    input  logic [31:0]      cmd_dat_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_dat_o,
    output logic             rsp_err_o,
    output logic             rsp_last_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i,
    output logic             busy_o
);

    // The timer only has to reach TIMEOUT-1.
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]    TIMER_ONE  = TW'(1);
    localparam logic [LEN_W-1:0] BEAT_ONE   = LEN_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic              cyc_r, cyc_s;
    logic              we_r, we_s;
    logic [3:0]        sel_r, sel_s;
    logic [31:0]       adr_r, adr_s;
    logic [31:0]       dat_r, dat_s;
    logic [LEN_W-1:0]  beats_r, beats_s;
    logic [TW-1:0]     timer_r, timer_s;
    logic              rsp_valid_r, rsp_valid_s;
    logic [31:0]       rsp_dat_r, rsp_dat_s;
    logic              rsp_err_r, rsp_err_s;
    logic              rsp_last_r, rsp_last_s;
    logic              cmd_ready_r, cmd_ready_s;
    logic              busy_r, busy_s;

    // Next-state and next-output logic for the command/beat/response sequencer.
    always_comb begin
        state_s     = state_r;
        cyc_s       = cyc_r;
        we_s        = we_r;
        sel_s       = sel_r;
        adr_s       = adr_r;
        dat_s       = dat_r;
        beats_s     = beats_r;
        timer_s     = timer_r;
        rsp_valid_s = rsp_valid_r;
        rsp_dat_s   = rsp_dat_r;
        rsp_err_s   = rsp_err_r;
        rsp_last_s  = rsp_last_r;

        case (state_r)
            IDLE: begin
                // cmd_ready_r is only ever high in IDLE, so this is the accept.
                if (cmd_valid_i && cmd_ready_r) begin
                    we_s    = cmd_we_i;
                    sel_s   = cmd_sel_i;
                    adr_s   = cmd_adr_i;
                    dat_s   = cmd_dat_i;
                    beats_s = cmd_len_i;
                    timer_s = '0;
                    cyc_s   = 1'b1;
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                // ACK is checked first so that it wins on the timeout cycle.
                if (wbm_ack_i) begin
                    cyc_s       = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_dat_s   = we_r ? 32'h0000_0000 : wbm_dat_i;
                    rsp_err_s   = 1'b0;
                    rsp_last_s  = (beats_r == '0);
                    state_s     = RSP;
                end else if (timer_r == TIMER_LAST) begin
                    cyc_s       = 1'b0;
                    rsp_valid_s = 1'b1;
                    rsp_dat_s   = 32'h0000_0000;
                    rsp_err_s   = 1'b1;
                    rsp_last_s  = 1'b1;
                    state_s     = RSP;
                end else begin
                    timer_s = timer_r + TIMER_ONE;
                    state_s = REQ;
                end
            end
            RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_s = 1'b0;
                    if (rsp_last_r) begin
                        state_s = IDLE;
                    end else begin
                        // Address wraps naturally in 32 bits.
                        adr_s   = adr_r + 32'd4;
                        beats_s = beats_r - BEAT_ONE;
                        timer_s = '0;
                        cyc_s   = 1'b1;
                        state_s = REQ;
                    end
                end else begin
                    state_s = RSP;
                end
            end
            default: begin
                cyc_s       = 1'b0;
                rsp_valid_s = 1'b0;
                state_s     = IDLE;
            end
        endcase

        // Handshake and status flags are registered from the next state.
        cmd_ready_s = (state_s == IDLE);
        busy_s      = (state_s != IDLE);
    end

    // State and output registers; reset clears every output immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_r     <= IDLE;
            cyc_r       <= 1'b0;
            we_r        <= 1'b0;
            sel_r       <= 4'h0;
            adr_r       <= 32'h0000_0000;
            dat_r       <= 32'h0000_0000;
            beats_r     <= '0;
            timer_r     <= '0;
            rsp_valid_r <= 1'b0;
            rsp_dat_r   <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            rsp_last_r  <= 1'b0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            cyc_r       <= cyc_s;
            we_r        <= we_s;
            sel_r       <= sel_s;
            adr_r       <= adr_s;
            dat_r       <= dat_s;
            beats_r     <= beats_s;
            timer_r     <= timer_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_dat_r   <= rsp_dat_s;
            rsp_err_r   <= rsp_err_s;
            rsp_last_r  <= rsp_last_s;
            cmd_ready_r <= cmd_ready_s;
            busy_r      <= busy_s;
        end
    end

    assign cmd_ready_o = cmd_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_dat_o   = rsp_dat_r;
    assign rsp_err_o   = rsp_err_r;
    assign rsp_last_o  = rsp_last_r;
    assign wbm_cyc_o   = cyc_r;
    assign wbm_stb_o   = cyc_r;
    assign wbm_we_o    = we_r;
    assign wbm_sel_o   = sel_r;
    assign wbm_adr_o   = adr_r;
    assign wbm_dat_o   = dat_r;
    assign busy_o      = busy_r;

endmodule

// File: tb/tb_wb_master_seq.sv
// ----------------------------------------------------------------------------
// tb_wb_master_seq
//   Directed and randomized bench for wb_master_seq (TIMEOUT=8, LEN_W=4).
//   A behavioural Wishbone slave answers strobes after a programmable wait
//   and for a programmable number of beats, then stops acknowledging.
//   Expected responses and WB transfers are computed per command from the
//   transfer rules (address = base + 4*beat, fill data, timeout abort).
// ----------------------------------------------------------------------------
module tb_wb_master_seq;

    localparam int TIMEOUT = 8;
    localparam int LEN_W   = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [3:0]  cmd_sel = 4'h0;
    logic [31:0] cmd_adr = 32'h0;
    logic [31:0] cmd_dat = 32'h0;
    logic [3:0]  cmd_len = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_last;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic [31:0] rdat = 32'h0;
    logic        ack = 1'b0;
    logic        busy;

    wb_master_seq #(.TIMEOUT(TIMEOUT), .LEN_W(LEN_W)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_we_i(cmd_we), .cmd_sel_i(cmd_sel), .cmd_adr_i(cmd_adr),
        .cmd_dat_i(cmd_dat), .cmd_len_i(cmd_len),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err), .rsp_last_o(rsp_last),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(wdat), .wbm_dat_i(rdat),
        .wbm_ack_i(ack), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        logic        err;
        logic        last;
    } rsp_t;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
    } wb_t;

    wb_t  wb_log[$];
    wb_t  exp_wb[$];
    rsp_t exp_rsp[$];

    int n_asserts = 0;
    int n_fail    = 0;

    // Slave configuration
    int          slave_wait  = 0;
    int          ack_limit   = 16;
    int          acks_done   = 0;
    int          waited      = 0;
    int          stb_hi      = 0;
    bit          rd_fixed_en = 1'b0;
    logic [31:0] rd_fixed    = 32'h0;
    int          last_lat    = 0;

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return rd_fixed_en ? rd_fixed : (a ^ 32'h5EED_1234);
    endfunction

    // Behavioural WB slave, updated on the falling edge.
    always @(negedge clk) begin
        if (stb) stb_hi = stb_hi + 1;
        if (!rst_n) begin
            ack = 1'b0;
            waited = 0;
        end else if (stb && !ack) begin
            if (acks_done < ack_limit && waited >= slave_wait) begin
                ack = 1'b1;
                rdat = slave_rd(adr);
                wb_log.push_back('{adr: adr, dat: wdat, we: we, sel: sel});
                acks_done = acks_done + 1;
                waited = 0;
            end else begin
                waited = waited + 1;
            end
        end else begin
            ack = 1'b0;
            waited = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Build the expected WB transfers and responses for one command.
    task automatic build_model(input logic c_we, input logic [3:0] c_sel,
                               input logic [31:0] c_adr, input logic [31:0] c_dat,
                               input int c_len, input int lim);
        int n_ok;
        logic [31:0] a;
        exp_wb.delete();
        exp_rsp.delete();
        n_ok = (lim < c_len + 1) ? lim : c_len + 1;
        for (int i = 0; i < n_ok; i++) begin
            a = c_adr + 32'(4 * i);
            exp_wb.push_back('{adr: a, dat: c_dat, we: c_we, sel: c_sel});
            exp_rsp.push_back('{dat: (c_we ? 32'h0 : slave_rd(a)), err: 1'b0,
                                last: (i == c_len)});
        end
        if (n_ok < c_len + 1)
            exp_rsp.push_back('{dat: 32'h0, err: 1'b1, last: 1'b1});
    endtask

    task automatic run_cmd(input logic c_we, input logic [3:0] c_sel,
                           input logic [31:0] c_adr, input logic [31:0] c_dat,
                           input logic [3:0] c_len, input int wt, input int lim,
                           input int hold);
        int cnt;
        int lat;
        rsp_t e;
        build_model(c_we, c_sel, c_adr, c_dat, int'(c_len), lim);
        @(negedge clk);
        slave_wait = wt;
        ack_limit  = lim;
        acks_done  = 0;
        wb_log.delete();
        cmd_we = c_we; cmd_sel = c_sel; cmd_adr = c_adr; cmd_dat = c_dat;
        cmd_len = c_len; cmd_valid = 1'b1;
        cnt = 0;
        while (!cmd_ready && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int k = 0; k < exp_rsp.size(); k++) begin
            e = exp_rsp[k];
            lat = 1;
            cnt = 0;
            while (!rsp_valid && cnt < 100) begin
                chk("stb_eq_cyc", stb, cyc);
                if (stb) begin
                    chk("wb_adr", adr, c_adr + 32'(4 * k));
                    chk("wb_we", we, c_we);
                end
                @(negedge clk);
                lat++;
                cnt++;
            end
            if (k == 0) last_lat = lat;
            chk("rsp_wait", rsp_valid, 1);
            if (!rsp_valid) return;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_valid", rsp_valid, 1);
                chk("hold_dat", rsp_dat, e.dat);
                chk("hold_no_stb", stb, 0);
            end
            chk("rsp_dat", rsp_dat, e.dat);
            chk("rsp_err", rsp_err, e.err);
            chk("rsp_last", rsp_last, e.last);
            rsp_ready = 1'b1;
            @(negedge clk);
            rsp_ready = 1'b0;
        end
        chk("busy_end", busy, 0);
        chk("ready_end", cmd_ready, 1);
        chk("valid_end", rsp_valid, 0);
        chk("wb_count", wb_log.size(), exp_wb.size());
        for (int k = 0; k < exp_wb.size() && k < wb_log.size(); k++) begin
            chk("log_adr", wb_log[k].adr, exp_wb[k].adr);
            chk("log_sel", wb_log[k].sel, exp_wb[k].sel);
            chk("log_we", wb_log[k].we, exp_wb[k].we);
            if (exp_wb[k].we) chk("log_dat", wb_log[k].dat, exp_wb[k].dat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int cnt;
        logic [31:0] r;
        logic [31:0] a;
        logic [3:0]  l;
        int lim;

        // Reset values
        #1;
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_dat", rsp_dat, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_last", rsp_last, 0);
        chk("rst_cyc", cyc, 0);
        chk("rst_stb", stb, 0);
        chk("rst_we", we, 0);
        chk("rst_sel", sel, 0);
        chk("rst_adr", adr, 0);
        chk("rst_wdat", wdat, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);

        // 1: single read, slave ACKs one cycle after STB
        rd_fixed_en = 1'b1;
        rd_fixed = 32'h0000_1234;
        s0 = stb_hi;
        run_cmd(1'b0, 4'hF, 32'h3000_0000, 32'h0, 4'd0, 1, 16, 0);
        chk("t1_stb_cycles", stb_hi - s0, 2);
        chk("t1_latency", last_lat, 3);
        rd_fixed_en = 1'b0;

        // 2: write fill, three beats
        run_cmd(1'b1, 4'hF, 32'h3000_0000, 32'hA5A5_0F0F, 4'd2, 0, 16, 0);

        // 3: timeout, slave never ACKs
        s0 = stb_hi;
        run_cmd(1'b0, 4'h3, 32'h3000_0010, 32'h0, 4'd0, 0, 0, 0);
        chk("t3_stb_cycles", stb_hi - s0, TIMEOUT);

        // ACK arriving on the final timeout cycle wins
        s0 = stb_hi;
        run_cmd(1'b0, 4'hF, 32'h3000_0020, 32'h0, 4'd0, TIMEOUT - 1, 16, 0);
        chk("ack_on_timeout_stb", stb_hi - s0, TIMEOUT);

        // Timeout in the middle of a burst
        run_cmd(1'b1, 4'h5, 32'h3000_0100, 32'h1357_9BDF, 4'd3, 1, 2, 1);

        // 4: backpressure on a two-beat read
        run_cmd(1'b0, 4'hF, 32'h3000_0040, 32'h0, 4'd1, 1, 16, 5);

        // 5: address wrap
        run_cmd(1'b0, 4'hC, 32'hFFFF_FFFC, 32'h0, 4'd1, 0, 16, 0);

        // 6: reset during beat 2 of a four-beat read
        @(negedge clk);
        slave_wait = 2; ack_limit = 16; acks_done = 0;
        wb_log.delete();
        cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_0200;
        cmd_len = 4'd3; cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cnt = 0;
        while (!(wb_log.size() == 1 && stb && !rsp_valid) && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("t6_beat2_stb", stb, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_cyc", cyc, 0);
        chk("t6_stb", stb, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        chk("t6_busy", busy, 0);
        rsp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_cmd(1'b1, 4'hF, 32'h3000_0300, 32'hDEAD_BEEF, 4'd1, 0, 16, 0);

        // Randomized commands
        for (int n = 0; n < 25; n++) begin
            r = $urandom;
            a = {r[31:2], 2'b00};
            r = $urandom;
            l = r[3:0];
            lim = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, int'(l))) : 16;
            run_cmd(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
                    l, int'($urandom_range(0, 3)), lim, int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
